// File: rtl/ddr_deser_pkg.sv
// Shared constants and elaboration helpers for the DDR deserializer.
package ddr_deser_pkg;

  localparam int   PAIR     = 2;
  localparam logic PHASE_FR = 1'b0;
  localparam logic PHASE_RF = 1'b1;

  function automatic bit width_ok(input int width);
    return (width >= PAIR) && ((width % PAIR) == 0);
  endfunction

  // Pair counter width: enough to count WIDTH/2 pairs, never narrower than one bit.
  function automatic int cnt_w_of(input int width);
    int n = 1;
    while ((1 << n) < (width / PAIR)) n++;
    return n;
  endfunction

endpackage

// File: rtl/ddr_deser_gray_det_ff_cell.sv
// One-bit XNOR dual-edge flop: output follows d after every clk edge.
// Only present in builds with DDR_DESER_DET_OUT_EN defined.
`ifdef DDR_DESER_DET_OUT_EN
module det_ff_cell (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic out
);

  logic q1_q, q2_q;
  logic q1_d, q2_d;
  logic q1n, q2n;

  assign q1n = ~q1_q;
  assign q2n = ~q2_q;

  always_comb begin
    q1_d = ~(d ^ q2n);
    q2_d = ~(d ^ q1n);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) q1_q <= 1'b0;
    else       q1_q <= q1_d;
  end

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) q2_q <= 1'b0;
    else       q2_q <= q2_d;
  end

  assign out = ~(q1_q ^ q2n);

endmodule
`endif

// File: rtl/ddr_deser_gray.sv
// Multi-lane DDR serial-to-parallel deserializer with half-cycle bitslip.
// Define DDR_DESER_DET_OUT_EN to add a dual-edge retimed copy of d on det_out.
module ddr_deser_gray
  import ddr_deser_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic                      bitslip,
  input  logic [CHANNELS-1:0]       d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic                      valid,
  output logic                      phase,
  output logic [CHANNELS-1:0]       det_out
);

  localparam int              CNT_W    = cnt_w_of(WIDTH);
  localparam int              HALF     = WIDTH / PAIR;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("ddr_deser_gray: WIDTH must be even and >= 2");
  end

  logic [CHANNELS-1:0]                 rise_q, fall_q;
  logic [CHANNELS-1:0][WIDTH-1:0]      sh_q, sh_d, shifted;
  logic [CHANNELS-1:0][PAIR-1:0]       pair;
  logic [CHANNELS*WIDTH-1:0]           q_q, q_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                valid_q, valid_d;
  logic                                phase_q, phase_d;

  // Phase RF pairs the previous rise with the fall after it; phase FR pairs that fall with the current rise.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign pair[c] = (phase_q == PHASE_RF) ? {rise_q[c], fall_q[c]} : {fall_q[c], d[c]};
    if (WIDTH == PAIR) begin : g_w2
      assign shifted[c] = pair[c];
    end else begin : g_wn
      assign shifted[c] = {sh_q[c][WIDTH-PAIR-1:0], pair[c]};
    end
  end

  always_comb begin
    sh_d    = sh_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    if (bitslip) begin
      phase_d = ~phase_q;
      cnt_d   = '0;
    end else if (en) begin
      sh_d = shifted;
      if (cnt_q == CNT_LAST) begin
        q_d     = shifted;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rise_q  <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      phase_q <= PHASE_FR;
    end else begin
      rise_q  <= d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
    end
  end

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) fall_q <= '0;
    else       fall_q <= d;
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign phase = phase_q;

`ifdef DDR_DESER_DET_OUT_EN
  for (genvar c = 0; c < CHANNELS; c++) begin : g_det
    det_ff_cell u_det (
      .clk  (clk),
      .rstb (rstb),
      .d    (d[c]),
      .out  (det_out[c])
    );
  end
`else
  assign det_out = '0;
`endif

endmodule

// File: tb/tb_ddr_deser_gray.sv
// Directed bench for ddr_deser_gray: 3-lane WIDTH=8 instance plus a WIDTH=2 instance on lane 0.
// Lane 1 always carries 1s and lane 2 always 0s; lane 0 carries the test words.
module tb_ddr_deser_gray;

  localparam int CH = 3;
  localparam int W  = 8;

`ifdef DDR_DESER_DET_OUT_EN
  localparam bit DET_EN = 1'b1;
`else
  localparam bit DET_EN = 1'b0;
`endif

  typedef struct {
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic          en;
    logic          bs;
    logic          exp_valid;
    logic [23:0]   exp_q;
    logic          exp_phase;
  } vec_t;

  logic            clk, rstb, en, bitslip;
  logic [CH-1:0]   d;
  logic [CH*W-1:0] q;
  logic            valid, phase;
  logic [CH-1:0]   det_out;
  logic [1:0]      q2;
  logic            valid2, phase2, det2;

  int   total, bad;
  vec_t vecs[41];

  ddr_deser_gray #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .en(en), .bitslip(bitslip), .d(d),
    .q(q), .valid(valid), .phase(phase), .det_out(det_out)
  );

  ddr_deser_gray #(.CHANNELS(1), .WIDTH(2)) dut_w2 (
    .clk(clk), .rstb(rstb), .en(en), .bitslip(bitslip), .d(d[0]),
    .q(q2), .valid(valid2), .phase(phase2), .det_out(det2)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input bit r0, input bit f0, input bit e, input bit b,
                              input bit v, input logic [23:0] eq, input bit ph);
    vec_t t;
    t.r = {2'b01, r0};
    t.f = {2'b01, f0};
    t.en = e;
    t.bs = b;
    t.exp_valid = v;
    t.exp_q = eq;
    t.exp_phase = ph;
    return t;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the rise sample before posedge and the fall sample before negedge; returns at negedge+1.
  task automatic applyStimulus(input logic [CH-1:0] rise_d, input logic [CH-1:0] fall_d,
                               input logic e, input logic b);
    d = rise_d;
    en = e;
    bitslip = b;
    @(posedge clk);
    #1;
    d = fall_d;
    bitslip = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] exp_q, input logic exp_v,
                             input logic exp_ph, input logic [CH-1:0] exp_det);
    checkValue({tag, ".q"}, 32'(q), 32'(exp_q));
    checkValue({tag, ".valid"}, 32'(valid), 32'(exp_v));
    checkValue({tag, ".phase"}, 32'(phase), 32'(exp_ph));
    checkValue({tag, ".det_out"}, 32'(det_out), DET_EN ? 32'(exp_det) : 32'd0);
  endtask

  logic          pr, pf, pph, v2_exp;
  logic [1:0]    q2_exp;
  logic [CH-1:0] smp;

  initial begin
    total = 0;
    bad = 0;
    rstb = 1'b0;
    en = 1'b0;
    bitslip = 1'b0;
    d = '0;

    // lane0 words: A5, A5, 3C, misaligned A5 (52), bitslip -> A5, slip at completion, 96, en gap, C3
    vecs[0]  = mk(1, 1, 0, 0, 0, 24'h000000, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 24'h000000, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 24'h000000, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 24'h000000, 0);
    vecs[4]  = mk(1, 1, 1, 0, 1, 24'h00FFA5, 0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 24'h00FFA5, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 24'h00FFA5, 0);
    vecs[7]  = mk(1, 0, 1, 0, 0, 24'h00FFA5, 0);
    vecs[8]  = mk(1, 0, 1, 0, 1, 24'h00FFA5, 0);
    vecs[9]  = mk(0, 1, 1, 0, 0, 24'h00FFA5, 0);
    vecs[10] = mk(1, 1, 1, 0, 0, 24'h00FFA5, 0);
    vecs[11] = mk(1, 0, 1, 0, 0, 24'h00FFA5, 0);
    vecs[12] = mk(0, 0, 1, 0, 1, 24'h00FF3C, 0);
    vecs[13] = mk(1, 0, 1, 0, 0, 24'h00FF3C, 0);
    vecs[14] = mk(1, 0, 1, 0, 0, 24'h00FF3C, 0);
    vecs[15] = mk(0, 1, 1, 0, 0, 24'h00FF3C, 0);
    vecs[16] = mk(0, 1, 1, 0, 1, 24'h00FF52, 0);
    vecs[17] = mk(1, 0, 1, 1, 0, 24'h00FF52, 1);
    vecs[18] = mk(1, 0, 1, 0, 0, 24'h00FF52, 1);
    vecs[19] = mk(0, 1, 1, 0, 0, 24'h00FF52, 1);
    vecs[20] = mk(0, 1, 1, 0, 0, 24'h00FF52, 1);
    vecs[21] = mk(1, 0, 1, 0, 1, 24'h00FFA5, 1);
    vecs[22] = mk(1, 0, 1, 0, 0, 24'h00FFA5, 1);
    vecs[23] = mk(0, 1, 1, 0, 0, 24'h00FFA5, 1);
    vecs[24] = mk(0, 1, 1, 0, 0, 24'h00FFA5, 1);
    vecs[25] = mk(1, 1, 1, 1, 0, 24'h00FFA5, 0);
    vecs[26] = mk(0, 0, 1, 0, 0, 24'h00FFA5, 0);
    vecs[27] = mk(1, 0, 1, 0, 0, 24'h00FFA5, 0);
    vecs[28] = mk(1, 1, 1, 0, 0, 24'h00FFA5, 0);
    vecs[29] = mk(0, 1, 1, 0, 1, 24'h00FF96, 0);
    vecs[30] = mk(1, 0, 1, 0, 0, 24'h00FF96, 0);
    vecs[31] = mk(0, 1, 1, 0, 0, 24'h00FF96, 0);
    vecs[32] = mk(1, 1, 0, 0, 0, 24'h00FF96, 0);
    vecs[33] = mk(1, 1, 0, 0, 0, 24'h00FF96, 0);
    vecs[34] = mk(1, 1, 0, 0, 0, 24'h00FF96, 0);
    vecs[35] = mk(1, 1, 0, 0, 0, 24'h00FF96, 0);
    vecs[36] = mk(1, 0, 0, 0, 0, 24'h00FF96, 0);
    vecs[37] = mk(0, 1, 1, 0, 0, 24'h00FF96, 0);
    vecs[38] = mk(1, 0, 1, 0, 1, 24'h00FFC3, 0);
    vecs[39] = mk(0, 0, 0, 1, 0, 24'h00FFC3, 1);
    vecs[40] = mk(0, 0, 0, 0, 0, 24'h00FFC3, 1);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", 24'h0, 1'b0, 1'b0, '0);
    checkValue("reset.q2", 32'(q2), 32'd0);
    checkValue("reset.valid2", 32'(valid2), 32'd0);
    rstb = 1'b1;

    pr = 1'b0;
    pf = 1'b0;
    pph = 1'b0;
    q2_exp = 2'b00;
    for (int i = 0; i < 41; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].en, vecs[i].bs);
      checkOutput($sformatf("v%0d", i), vecs[i].exp_q, vecs[i].exp_valid, vecs[i].exp_phase, vecs[i].f);
      v2_exp = 1'b0;
      if (!vecs[i].bs && vecs[i].en) begin
        q2_exp = pph ? {pr, pf} : {pf, vecs[i].r[0]};
        v2_exp = 1'b1;
      end
      checkValue($sformatf("v%0d.w2_q", i), 32'(q2), 32'(q2_exp));
      checkValue($sformatf("v%0d.w2_valid", i), 32'(valid2), 32'(v2_exp));
      checkValue($sformatf("v%0d.w2_phase", i), 32'(phase2), 32'(vecs[i].exp_phase));
      pr = vecs[i].r[0];
      pf = vecs[i].f[0];
      pph = vecs[i].exp_phase;
    end

    // Three pairs into a phase-1 word, then asynchronous reset mid-cycle.
    applyStimulus(3'b011, 3'b010, 1'b1, 1'b0);
    applyStimulus(3'b011, 3'b011, 1'b1, 1'b0);
    applyStimulus(3'b010, 3'b011, 1'b1, 1'b0);
    checkOutput("pre_rst", 24'h00FFC3, 1'b0, 1'b1, 3'b011);
    #50;
    rstb = 1'b0;
    #1;
    checkOutput("mid_rst", 24'h0, 1'b0, 1'b0, '0);
    checkValue("mid_rst.q2", 32'(q2), 32'd0);
    @(negedge clk);
    #1;
    rstb = 1'b1;

    // First word after reset: lane0 5A, lane1 loses its first bit to the cleared fall sample.
    applyStimulus(3'b011, 3'b010, 1'b1, 1'b0);
    checkOutput("post_rst1", 24'h0, 1'b0, 1'b0, 3'b010);
    applyStimulus(3'b011, 3'b011, 1'b1, 1'b0);
    checkOutput("post_rst2", 24'h0, 1'b0, 1'b0, 3'b011);
    applyStimulus(3'b010, 3'b011, 1'b1, 1'b0);
    checkOutput("post_rst3", 24'h0, 1'b0, 1'b0, 3'b011);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkOutput("post_rst4", 24'h007F5A, 1'b1, 1'b0, 3'b010);
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0);
    checkOutput("post_rst5", 24'h007F5A, 1'b0, 1'b0, 3'b010);

    // det_out against d toggling every 78 time units, never on a clock edge.
    en = 1'b0;
    d = '0;
    @(posedge clk);
    #7;
    fork
      begin
        repeat (60) begin
          #78;
          d = ~d;
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(clk);
          smp = d;
          #1;
          checkValue($sformatf("det%0d", k), 32'(det_out), DET_EN ? 32'(smp) : 32'd0);
          checkValue($sformatf("det%0d.w2", k), 32'(det2), DET_EN ? 32'(smp[0]) : 32'd0);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
